vga_screen_ctrl: RTL and testbench
==================================

# vga_screen_ctrl

Screen sequencer and output arbiter for the game's VGA display. Owns the single 800x525 raster timing counter, and exports the position to the four screen generators (title, play, win, lose). Takes game events, commits screen changes only at frame boundaries, and muxes the selected generator's pixel onto the VGA pins with sync aligned. With it in place, no screen generator drives hsync/vsync itself.

## Interface
Parameters:
- `H_TOTAL`, default 800: pixels per line, counter 0..H_TOTAL-1.
- `V_TOTAL`, default 525: lines per frame, counter 0..V_TOTAL-1.
- `HOLD_FRAMES`, default 180: frames the WIN/LOSE screen is held before auto-return (≥1).

Ports:
- `clk`  in  1  pixel clock (25 MHz).
- `clr`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  start request, level-sampled every cycle.
- `win_i`  in  1  win event, level-sampled.
- `lose_i`  in  1  lose event, level-sampled.
- `title_rgb_i`, `play_rgb_i`, `win_rgb_i`, `lose_rgb_i`  in  12 each  {r,g,b} from generators, registered one cycle after x_o/y_o.
- `x_o`  out  10  horizontal counter.
- `y_o`  out  10  vertical counter.
- `frame_start_o`  out  1  high for the single cycle where x_o==0 and y_o==0.
- `screen_o`  out  2  committed screen: 0 TITLE, 1 PLAY, 2 WIN, 3 LOSE.
- `hsync`, `vsync`  out  1 each  VGA syncs, active-low.
- `r`, `g`, `b`  out  4 each  pixel colour.

## Operation
- Counters: x increments each cycle and wraps H_TOTAL-1→0. y increments when x wraps and wraps V_TOTAL-1→0 on the same cycle.
- Frame boundary (FB): the cycle with x==H_TOTAL-1 and y==V_TOTAL-1.
- FSM states TITLE, PLAY, WIN, LOSE. Legal requests:
  - start in TITLE/WIN/LOSE → PLAY.
  - lose in PLAY → LOSE.
  - win in PLAY → WIN.
  - Requests illegal in the current state are ignored.
- Pending register: legal requests are latched at any cycle, with priority lose > win > start. A later higher-priority request overwrites a pending lower one; a lower one never overwrites a higher one.
- At FB the pending request commits: screen_o changes on the cycle after FB, coincident with x=y=0, and pending clears. A request sampled on the FB cycle itself is not committed at that FB; it is latched and commits at the next FB.
- Hold counter: cleared on entry to WIN/LOSE and incremented at each FB while in WIN/LOSE (see Configuration for auto-return).
- Pixel mux: select the generator rgb by screen_o. Output colour is zero outside the active window 144≤x≤783, 35≤y≤514, evaluated on the position delayed to match the data.

## Timing
- Reset values:
  - x_o = y_o = 0.
  - frame_start_o = 1, since it follows the counter state.
  - screen_o = TITLE.
  - pending = none; hold = 0.
  - hsync = vsync = 0.
  - r = g = b = 0.
- Sync, raw position: hsync low for x in 0..95; vsync low for y in 0..1.
- Alignment: r/g/b, hsync and vsync are registered and appear 2 cycles after the counter value they describe. That is 1 cycle for the generator plus 1 output register, so sync and pixel stay aligned.
- Screen-change latency: from a request to the visible change is at most one frame + 3 cycles.
- Reset mid-frame: all state returns to reset values immediately (async). The first post-reset FB occurs after a full frame.

## Configuration
- `VGA_CTRL_AUTORET_EN` defined:
  - WIN/LOSE returns to TITLE at the FB where the hold counter equals HOLD_FRAMES-1.
  - A pending start at that same FB takes precedence and goes to PLAY.
- Not defined:
  - The hold counter logic is absent.
  - WIN/LOSE persist until start.

## Structure
- Package `vga_ctrl_pkg`:
  - screen enum (TITLE/PLAY/WIN/LOSE).
  - Active-window bounds 144/783/35/514 and sync widths 96/2.
  - RGB width 12.
- Sub-module `vga_timing_gen`: counters, FB and frame_start_o, raw sync. The controller adds the FSM, pending register, hold counter, delay pipeline and mux.

## Test plan
- Reset release, run 2 frames → hsync period 800 with 96 low; vsync period 420000 cycles with 1600 low; frame_start_o every 420000 cycles.
- start_i pulse at line 100 in TITLE → screen_o=PLAY from the cycle after the next FB, never earlier.
- In PLAY, win_i then lose_i in the same frame → LOSE committed. lose_i then win_i in the same frame → LOSE committed.
- With VGA_CTRL_AUTORET_EN and HOLD_FRAMES=3: enter LOSE → TITLE after 3 FBs. start_i during the hold → PLAY at the next FB.
- Generators drive play_rgb_i=12'hFFF, others 0, in PLAY → r/g/b=F only inside the active window, two cycles after x∈144..783, y∈35..514; 0 at x=143 and x=784.
- clr asserted mid-frame in WIN with pending start → immediate reset values; TITLE after release, pending start lost.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// vga_ctrl_pkg: shared types and constants for the VGA screen controller.
// Holds the screen and request encodings, the 640x480 active window
// bounds inside the 800x525 raster, the sync pulse widths and the colour
// width, plus small helpers that give the request rules one definition.
package vga_ctrl_pkg;

    localparam int POS_W       = 10;
    localparam int RGB_W       = 12;

    localparam int H_ACT_FIRST = 144;
    localparam int H_ACT_LAST  = 783;
    localparam int V_ACT_FIRST = 35;
    localparam int V_ACT_LAST  = 514;

    localparam int H_SYNC_W    = 96;
    localparam int V_SYNC_W    = 2;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } screen_e;

    // The encoding order is the request priority: a larger value wins.
    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_START = 2'd1,
        REQ_WIN   = 2'd2,
        REQ_LOSE  = 2'd3
    } req_e;

    // A request only means something from certain screens.
    function automatic logic req_legal(input req_e req, input screen_e scr);
        logic ok;
        ok = 1'b0;
        case (req)
            REQ_START: ok = (scr != PLAY);
            REQ_WIN:   ok = (scr == PLAY);
            REQ_LOSE:  ok = (scr == PLAY);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Screen a request leads to once it is committed.
    function automatic screen_e req_target(input req_e req);
        screen_e scr;
        scr = TITLE;
        case (req)
            REQ_START: scr = PLAY;
            REQ_WIN:   scr = WIN;
            REQ_LOSE:  scr = LOSE;
            default:   scr = TITLE;
        endcase
        return scr;
    endfunction

    // True when a raster position lies inside the visible picture.
    function automatic logic in_active(input logic [POS_W-1:0] x,
                                       input logic [POS_W-1:0] y);
        return (x >= POS_W'(H_ACT_FIRST)) && (x <= POS_W'(H_ACT_LAST)) &&
               (y >= POS_W'(V_ACT_FIRST)) && (y <= POS_W'(V_ACT_LAST));
    endfunction

endpackage

// File: rtl/vga_screen_ctrl_if.sv
// vga_screen_ctrl_if: bus between the screen controller and the four
// screen generators. The controller (master) publishes the raster position,
// the frame-start strobe and the committed screen; each generator (slave)
// returns its colour one cycle after the position it was given.
interface vga_screen_ctrl_if;
    import vga_ctrl_pkg::*;

    logic [POS_W-1:0] x_o;
    logic [POS_W-1:0] y_o;
    logic             frame_start_o;
    screen_e          screen_o;

    logic [RGB_W-1:0] title_rgb_i;
    logic [RGB_W-1:0] play_rgb_i;
    logic [RGB_W-1:0] win_rgb_i;
    logic [RGB_W-1:0] lose_rgb_i;

    modport master (
        output x_o,
        output y_o,
        output frame_start_o,
        output screen_o,
        input  title_rgb_i,
        input  play_rgb_i,
        input  win_rgb_i,
        input  lose_rgb_i
    );

    modport slave (
        input  x_o,
        input  y_o,
        input  frame_start_o,
        input  screen_o,
        output title_rgb_i,
        output play_rgb_i,
        output win_rgb_i,
        output lose_rgb_i
    );

endinterface

// File: rtl/vga_screen_ctrl_timing.sv
// vga_timing_gen: the one raster counter of the display. Produces the
// x/y position, the frame-boundary strobe (last pixel of the last line),
// the frame-start strobe (first pixel of the first line) and the raw,
// undelayed active-low syncs for the current position.
module vga_timing_gen
    import vga_ctrl_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             clr,
    output logic [POS_W-1:0] x_o,
    output logic [POS_W-1:0] y_o,
    output logic             fb_o,
    output logic             frame_start_o,
    output logic             hsync_raw_o,
    output logic             vsync_raw_o
);

    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             x_last;
    logic             y_last;

    // Next position: x wraps every line, y steps on the x wrap and wraps
    // on the same cycle when the frame ends.
    always_comb begin
        x_last = (x_q == POS_W'(H_TOTAL - 1));
        y_last = (y_q == POS_W'(V_TOTAL - 1));
        x_d    = x_last ? '0 : x_q + POS_W'(1);
        y_d    = y_q;
        if (x_last) begin
            y_d = y_last ? '0 : y_q + POS_W'(1);
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign fb_o          = x_last && y_last;
    assign frame_start_o = (x_q == '0) && (y_q == '0);
    assign hsync_raw_o   = (x_q >= POS_W'(H_SYNC_W));
    assign vsync_raw_o   = (y_q >= POS_W'(V_SYNC_W));

endmodule

// File: rtl/vga_screen_ctrl.sv
// vga_screen_ctrl: screen sequencer and VGA output arbiter.
// Owns the raster timing, latches game requests (lose > win > start) at
// any time and commits them only at the frame boundary, so a screen never
// changes mid-picture. The selected generator's colour is blanked outside
// the active window and registered together with the syncs so both reach
// the pins two cycles after the position they describe.
// Build option: define VGA_CTRL_AUTORET_EN to make WIN/LOSE fall back to
// TITLE after HOLD_FRAMES frames; without it they stay until a start.
module vga_screen_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int HOLD_FRAMES = 180
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start_i,
    input  logic                    win_i,
    input  logic                    lose_i,
    vga_screen_ctrl_if.master       gen,
    output logic                    hsync,
    output logic                    vsync,
    output logic [3:0]              r,
    output logic [3:0]              g,
    output logic [3:0]              b
);

    // A zero-frame hold would return before the screen was ever shown.
    if (HOLD_FRAMES < 1) begin : g_bad_hold
        $error("vga_screen_ctrl: HOLD_FRAMES must be at least 1");
    end

    logic [POS_W-1:0] x_cnt;
    logic [POS_W-1:0] y_cnt;
    logic             fb;
    logic             frame_start;
    logic             hs_raw;
    logic             vs_raw;

    vga_timing_gen #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing (
        .clk           (clk),
        .clr           (clr),
        .x_o           (x_cnt),
        .y_o           (y_cnt),
        .fb_o          (fb),
        .frame_start_o (frame_start),
        .hsync_raw_o   (hs_raw),
        .vsync_raw_o   (vs_raw)
    );

    screen_e screen_q;
    req_e    pend_q;
    req_e    new_req;
    logic    commit_ok;

`ifdef VGA_CTRL_AUTORET_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
    logic [15:0] hold_q;
    logic        in_end;
    assign in_end = (screen_q == WIN) || (screen_q == LOSE);
`endif

    // Pick the highest-priority request that is legal on the current screen,
    // and decide whether the pending one may still be applied.
    always_comb begin
        new_req = REQ_NONE;
        if (lose_i && req_legal(REQ_LOSE, screen_q)) begin
            new_req = REQ_LOSE;
        end else if (win_i && req_legal(REQ_WIN, screen_q)) begin
            new_req = REQ_WIN;
        end else if (start_i && req_legal(REQ_START, screen_q)) begin
            new_req = REQ_START;
        end
        commit_ok = req_legal(pend_q, screen_q);
    end

    // Screen FSM: requests accumulate in pend_q during the frame and are
    // committed on the boundary; a request seen on the boundary cycle
    // itself becomes the fresh pending entry for the next frame.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            screen_q <= TITLE;
            pend_q   <= REQ_NONE;
`ifdef VGA_CTRL_AUTORET_EN
            hold_q   <= '0;
`endif
        end else if (fb) begin
            pend_q <= new_req;
            if (commit_ok) begin
                screen_q <= req_target(pend_q);
`ifdef VGA_CTRL_AUTORET_EN
                hold_q   <= '0;
            end else if (in_end && (hold_q == HOLD_LAST)) begin
                screen_q <= TITLE;
                hold_q   <= '0;
            end else if (in_end) begin
                hold_q   <= hold_q + 16'd1;
`endif
            end
        end else if (new_req > pend_q) begin
            pend_q <= new_req;
        end
    end

    logic [POS_W-1:0] x1_q;
    logic [POS_W-1:0] y1_q;
    logic             hs1_q;
    logic             vs1_q;
    logic [RGB_W-1:0] sel_rgb;
    logic [RGB_W-1:0] rgb_q;
    logic             hs_q;
    logic             vs_q;

    // Route the committed screen's generator colour.
    always_comb begin
        sel_rgb = '0;
        case (screen_q)
            TITLE:   sel_rgb = gen.title_rgb_i;
            PLAY:    sel_rgb = gen.play_rgb_i;
            WIN:     sel_rgb = gen.win_rgb_i;
            LOSE:    sel_rgb = gen.lose_rgb_i;
            default: sel_rgb = '0;
        endcase
    end

    // First delay stage: holds position and syncs for the cycle the
    // generators need to turn that position into a colour.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x1_q  <= '0;
            y1_q  <= '0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
        end else begin
            x1_q  <= x_cnt;
            y1_q  <= y_cnt;
            hs1_q <= hs_raw;
            vs1_q <= vs_raw;
        end
    end

    // Output registers: blank outside the window using the delayed position
    // so the colour and syncs on the pins describe the same pixel.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= in_active(x1_q, y1_q) ? sel_rgb : '0;
            hs_q  <= hs1_q;
            vs_q  <= vs1_q;
        end
    end

    assign gen.x_o           = x_cnt;
    assign gen.y_o           = y_cnt;
    assign gen.frame_start_o = frame_start;
    assign gen.screen_o      = screen_q;

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign r     = rgb_q[11:8];
    assign g     = rgb_q[7:4];
    assign b     = rgb_q[3:0];

endmodule

// File: tb/tb_vga_screen_ctrl.sv
// tb_vga_screen_ctrl: directed bench for the screen controller.
// dutB runs a tiny 16x8 raster so screen sequencing can be exercised over
// many frames; dutA uses the full 800x525 raster for sync and window
// timing over the first 36 lines. Expected values go into scoreboards
// when stimulus is applied and are popped when the DUT shows its result.
module tb_vga_screen_ctrl;
    import vga_ctrl_pkg::*;

    localparam int BH = 16;
    localparam int BV = 8;

    localparam logic [11:0] TITLE_RGB = 12'hABC;
    localparam logic [11:0] PLAY_RGB  = 12'h5F1;
    localparam logic [11:0] WIN_RGB   = 12'h2D7;
    localparam logic [11:0] LOSE_RGB  = 12'h964;

    logic clk = 1'b0;
    logic clrA, clrB;
    logic startI, winI, loseI;
    logic hsA, vsA, hsB, vsB;
    logic [3:0] rA, gA, bA, rB, gB, bB;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        bit          live;
    } sb_t;

    sb_t sbQ[$];
    sb_t pixQ[$];

    vga_screen_ctrl_if genA ();
    vga_screen_ctrl_if genB ();

    assign genA.title_rgb_i = TITLE_RGB;
    assign genA.play_rgb_i  = PLAY_RGB;
    assign genA.win_rgb_i   = WIN_RGB;
    assign genA.lose_rgb_i  = LOSE_RGB;
    assign genB.title_rgb_i = TITLE_RGB;
    assign genB.play_rgb_i  = PLAY_RGB;
    assign genB.win_rgb_i   = WIN_RGB;
    assign genB.lose_rgb_i  = LOSE_RGB;

    vga_screen_ctrl dutA (
        .clk (clk), .clr (clrA),
        .start_i (startI), .win_i (winI), .lose_i (loseI),
        .gen (genA),
        .hsync (hsA), .vsync (vsA), .r (rA), .g (gA), .b (bA)
    );

    vga_screen_ctrl #(
        .H_TOTAL (BH), .V_TOTAL (BV), .HOLD_FRAMES (3)
    ) dutB (
        .clk (clk), .clr (clrB),
        .start_i (startI), .win_i (winI), .lose_i (loseI),
        .gen (genB),
        .hsync (hsB), .vsync (vsB), .r (rB), .g (gB), .b (bB)
    );

    always #5 clk = ~clk;

    task automatic compareOne(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic expectValue(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag; e.exp = exp; e.live = 1'b1;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [15:0] observed);
        sb_t e;
        if (sbQ.size() == 0) begin
            checkCount++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=queued_entry", observed);
        end else begin
            e = sbQ.pop_front();
            compareOne(e.tag, observed, e.exp);
        end
    endtask

    task automatic checkPixel(input logic [15:0] observed);
        sb_t e;
        e = pixQ.pop_front();
        if (e.live) compareOne(e.tag, observed, e.exp);
    endtask

    // One-cycle request pulse driven from a negative edge.
    task automatic applyStimulus(input bit s, input bit w, input bit l);
        startI = s; winI = w; loseI = l;
        @(negedge clk);
        startI = 1'b0; winI = 1'b0; loseI = 1'b0;
    endtask

    task automatic waitPosB(input int x, input int y);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (int'(genB.x_o) == x && int'(genB.y_o) == y) found = 1'b1;
        end
        compareOne("wait_position", 16'(found), 16'd1);
    endtask

    // Waits for the next frame start; the screen must not change before it.
    task automatic waitFrameB(input string tag, input screen_e holdScr);
        bit found, early;
        found = 1'b0; early = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (genB.frame_start_o === 1'b1) found = 1'b1;
            else if (genB.screen_o !== holdScr) early = 1'b1;
        end
        compareOne({tag, "_frame_seen"}, 16'(found), 16'd1);
        compareOne({tag, "_no_early_change"}, 16'(early), 16'd0);
    endtask

    task automatic checkResetB(input string tag);
        expectValue({tag, "_x"}, 16'd0);            checkOutput(16'(genB.x_o));
        expectValue({tag, "_y"}, 16'd0);            checkOutput(16'(genB.y_o));
        expectValue({tag, "_frame_start"}, 16'd1);  checkOutput(16'(genB.frame_start_o));
        expectValue({tag, "_screen"}, 16'(TITLE));  checkOutput(16'(genB.screen_o));
        expectValue({tag, "_hsync"}, 16'd0);        checkOutput(16'(hsB));
        expectValue({tag, "_vsync"}, 16'd0);        checkOutput(16'(vsB));
        expectValue({tag, "_rgb"}, 16'd0);          checkOutput(16'({rB, gB, bB}));
    endtask

    task automatic stepScreen(input string tag, input bit s, input bit w, input bit l,
                              input screen_e fromScr, input screen_e toScr);
        waitPosB(0, 2);
        applyStimulus(s, w, l);
        expectValue(tag, 16'(toScr));
        waitFrameB(tag, fromScr);
        checkOutput(16'(genB.screen_o));
    endtask

    int  px, py, fbCycles;
    bit  hsE, vsE, actE, live, seen;
    sb_t pe;

    initial begin
        $display("[TB] start");
        clrA = 1'b1; clrB = 1'b1;
        startI = 1'b0; winI = 1'b0; loseI = 1'b0;
        repeat (3) @(negedge clk);
        checkResetB("reset");
        clrB = 1'b0;

        stepScreen("title_start", 1, 0, 0, TITLE, PLAY);
        stepScreen("play_illegal_start", 1, 0, 0, PLAY, PLAY);

        waitPosB(0, 2); applyStimulus(0, 1, 0);
        waitPosB(0, 4); applyStimulus(0, 0, 1);
        expectValue("win_then_lose", 16'(LOSE));
        waitFrameB("win_then_lose", PLAY);
        checkOutput(16'(genB.screen_o));

        stepScreen("lose_start", 1, 0, 0, LOSE, PLAY);

        waitPosB(0, 2); applyStimulus(0, 0, 1);
        waitPosB(0, 4); applyStimulus(0, 1, 0);
        expectValue("lose_then_win", 16'(LOSE));
        waitFrameB("lose_then_win", PLAY);
        checkOutput(16'(genB.screen_o));

        waitPosB(BH - 1, BV - 1);
        applyStimulus(1, 0, 0);
        expectValue("fb_frame_start", 16'd1);  checkOutput(16'(genB.frame_start_o));
        expectValue("fb_start_deferred", 16'(LOSE)); checkOutput(16'(genB.screen_o));
        expectValue("fb_start_commit", 16'(PLAY));
        waitFrameB("fb_start_commit", LOSE);
        checkOutput(16'(genB.screen_o));

        stepScreen("play_win", 0, 1, 0, PLAY, WIN);
`ifdef VGA_CTRL_AUTORET_EN
        expectValue("hold_win_1", 16'(WIN));   waitFrameB("hold_win_1", WIN); checkOutput(16'(genB.screen_o));
        expectValue("hold_win_2", 16'(WIN));   waitFrameB("hold_win_2", WIN); checkOutput(16'(genB.screen_o));
        expectValue("auto_return", 16'(TITLE)); waitFrameB("auto_return", WIN); checkOutput(16'(genB.screen_o));
        stepScreen("ret_title_start", 1, 0, 0, TITLE, PLAY);
        stepScreen("ret_play_lose", 0, 0, 1, PLAY, LOSE);
        expectValue("hold_lose_1", 16'(LOSE)); waitFrameB("hold_lose_1", LOSE); checkOutput(16'(genB.screen_o));
        expectValue("hold_lose_2", 16'(LOSE)); waitFrameB("hold_lose_2", LOSE); checkOutput(16'(genB.screen_o));
        stepScreen("hold_start_wins", 1, 0, 0, LOSE, PLAY);
        stepScreen("play_win_again", 0, 1, 0, PLAY, WIN);
`else
        for (int k = 0; k < 3; k++) begin
            expectValue("win_persists", 16'(WIN));
            waitFrameB("win_persists", WIN);
            checkOutput(16'(genB.screen_o));
        end
`endif

        waitPosB(0, 3); applyStimulus(1, 0, 0);
        waitPosB(0, 5);
        clrB = 1'b1;
        #1;
        checkResetB("mid_reset");
        @(negedge clk);
        clrB = 1'b0;
        fbCycles = 0; seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            fbCycles++;
            if (genB.frame_start_o === 1'b1) seen = 1'b1;
        end
        expectValue("first_fb_cycles", 16'(BH * BV)); checkOutput(16'(fbCycles));
        expectValue("pending_lost", 16'(TITLE));      checkOutput(16'(genB.screen_o));

        // Full-size raster: sync and window checks, two cycles behind position.
        pe.tag = "pix_reset"; pe.exp = 16'd0; pe.live = 1'b1;
        pixQ.push_back(pe); pixQ.push_back(pe);
        clrA = 1'b0;
        for (int t = 0; t <= 36 * 800 + 2; t++) begin
            if (t > 0) @(negedge clk);
            px   = t % 800;
            py   = t / 800;
            hsE  = (px >= 96);
            vsE  = (py >= 2);
            actE = (px >= 144) && (px <= 783) && (py >= 35) && (py <= 514);
            live = (py <= 2) || (py >= 34);
            pe.tag  = "pixel_sync";
            pe.exp  = {2'b00, hsE, vsE, (actE ? TITLE_RGB : 12'h000)};
            pe.live = live;
            pixQ.push_back(pe);
            checkPixel({2'b00, hsA, vsA, rA, gA, bA});
            if (live && px == 0) begin
                expectValue("pos_x", 16'd0);             checkOutput(16'(genA.x_o));
                expectValue("pos_y", 16'(py));           checkOutput(16'(genA.y_o));
                expectValue("frame_start", 16'(py == 0)); checkOutput(16'(genA.frame_start_o));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
